// File: rtl/logic_flags_pipe_if.sv
// -----------------------------------------------------------------------------
// logic_flags_pipe_if
//   Handshake bundle between a producer/consumer and logic_flags_pipe.
//
//   Input side  : in_valid, in_ready, a, b, op
//   Output side : out_valid, out_ready, result, zero, negative, carry, overflow
//
//   Valid/ready semantics (both sides): a transfer happens at a rising clock
//   edge where valid and ready are both 1. The sender holds its payload and
//   valid stable until that edge. Ready never depends combinationally on the
//   valid of the same side.
//
//   Modports:
//     master : the testbench or surrounding logic (drives operands, out_ready)
//     slave  : logic_flags_pipe itself
// -----------------------------------------------------------------------------
interface logic_flags_pipe_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             negative;
   logic             carry;
   logic             overflow;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, zero, negative, carry, overflow
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, zero, negative, carry, overflow
   );
endinterface

// File: rtl/logic_flags_pipe.sv
// -----------------------------------------------------------------------------
// logic_flags_pipe
//   One-stage registered logic unit (AND / OR / XOR / NOT A) with status
//   flags, a sticky zero flag and a modulo counter of accepted operations.
//
//   Parameters:
//     WIDTH  operand/result width (2..32)
//     CNT_W  width of the accepted-operation counter (1..16)
//
//   Ports:
//     clk          single clock, rising edge
//     rst          synchronous, active-high reset
//     bus          logic_flags_pipe_if.slave (operands in, result/flags out)
//     sticky_clr   clears sticky_zero (an accepted zero result wins)
//     sticky_zero  set by any accepted zero result, held until cleared
//     op_count     number of accepted bundles modulo 2^CNT_W
//     state_dbg    current FSM state (0 = EMPTY, 1 = FULL)
//
//   op encoding: 00 AND, 01 OR, 10 XOR, 11 NOT A (b ignored).
//   carry and overflow are always 0 for these logic operations; they are kept
//   as registered outputs so the flag set matches the arithmetic units.
// -----------------------------------------------------------------------------
module logic_flags_pipe #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   logic_flags_pipe_if.slave    bus,
   input  logic                 sticky_clr,
   output logic                 sticky_zero,
   output logic [CNT_W-1:0]     op_count,
   output logic                 state_dbg
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_XOR  = 2'b10;
   localparam logic [1:0] OP_NOTA = 2'b11;

   state_t           state;
   logic             out_valid_q;
   logic [WIDTH-1:0] result_q;
   logic             zero_q;
   logic             negative_q;
   logic             carry_q;
   logic             overflow_q;
   logic             sticky_q;
   logic [CNT_W-1:0] count_q;

   logic             in_ready_c;
   logic             accept;
   logic             deliver;
   logic [WIDTH-1:0] calc;
   logic             calc_zero;

   // The stage can take a new bundle when it is empty or when the held
   // result leaves in this same cycle. in_valid is deliberately absent here.
   assign in_ready_c = !rst && ((state == EMPTY) || bus.out_ready);
   assign accept     = bus.in_valid && in_ready_c;
   assign deliver    = out_valid_q && bus.out_ready;

   always_comb begin
      calc = '0;
      case (bus.op)
         OP_AND:  calc = bus.a & bus.b;
         OP_OR:   calc = bus.a | bus.b;
         OP_XOR:  calc = bus.a ^ bus.b;
         OP_NOTA: calc = ~bus.a;
         default: calc = '0;
      endcase
   end

   // Flags look only at the WIDTH-bit value that is actually loaded.
   assign calc_zero = (calc == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= EMPTY;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         negative_q  <= 1'b0;
         carry_q     <= 1'b0;
         overflow_q  <= 1'b0;
         sticky_q    <= 1'b0;
         count_q     <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  state       <= FULL;
                  out_valid_q <= 1'b1;
               end
            end
            FULL: begin
               // Simultaneous deliver and accept keeps the stage full with
               // the new result.
               if (deliver && !accept) begin
                  state       <= EMPTY;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state       <= EMPTY;
               out_valid_q <= 1'b0;
            end
         endcase

         if (accept) begin
            result_q   <= calc;
            zero_q     <= calc_zero;
            negative_q <= calc[WIDTH-1];
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            count_q    <= count_q + CNT_W'(1);
         end

         // Set has priority over clear.
         if (accept && calc_zero) begin
            sticky_q <= 1'b1;
         end else if (sticky_clr) begin
            sticky_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.negative  = negative_q;
   assign bus.carry     = carry_q;
   assign bus.overflow  = overflow_q;
   assign sticky_zero   = sticky_q;
   assign op_count      = count_q;
   assign state_dbg     = state;

endmodule

// File: tb/tb_logic_flags_pipe.sv
// -----------------------------------------------------------------------------
// tb_logic_flags_pipe
//   Two instances: dut0 (WIDTH=4, CNT_W=2) and dut1 (WIDTH=8, CNT_W=8).
//   A driver issues directed and random bundles; a monitor at each falling
//   edge checks every output against a reference model (pending-result queue,
//   counters) and pops/compares results as they are delivered.
// -----------------------------------------------------------------------------
module tb_logic_flags_pipe;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0, rst1;
   logic sclr0, sclr1;
   logic sz0, sz1;
   logic [1:0] cnt0;
   logic [7:0] cnt1;
   logic st0, st1;
   logic mon_on;

   logic_flags_pipe_if #(.WIDTH(4)) if0 ();
   logic_flags_pipe_if #(.WIDTH(8)) if1 ();

   logic_flags_pipe #(.WIDTH(4), .CNT_W(2)) dut0 (
      .clk(clk), .rst(rst0), .bus(if0), .sticky_clr(sclr0),
      .sticky_zero(sz0), .op_count(cnt0), .state_dbg(st0)
   );

   logic_flags_pipe #(.WIDTH(8), .CNT_W(8)) dut1 (
      .clk(clk), .rst(rst1), .bus(if1), .sticky_clr(sclr1),
      .sticky_zero(sz1), .op_count(cnt1), .state_dbg(st1)
   );

   // ---------------- scoreboard / model ----------------
   int total = 0;
   int bad   = 0;

   logic [7:0] exp_q0[$];
   logic [7:0] exp_q1[$];
   logic [7:0] m_res [2];
   logic       m_zero[2];
   logic       m_neg [2];
   logic       m_sz  [2];
   int         m_cnt [2];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Logic result masked to w bits; NOT A is the w-bit all-ones minus a.
   function automatic logic [7:0] model_op(input logic [1:0] o, input logic [7:0] x,
                                           input logic [7:0] y, input int w);
      int mask;
      int r;
      mask = (1 << w) - 1;
      case (o)
         2'd0:    r = int'(x & y);
         2'd1:    r = int'(x | y);
         2'd2:    r = int'(x ^ y);
         default: r = mask - int'(x);
      endcase
      return 8'(r & mask);
   endfunction

   task automatic mon_step(input int d, input logic r, input logic iv,
                           input logic [7:0] ia, input logic [7:0] ib, input logic [1:0] iop,
                           input logic ordy, input logic sclr,
                           input logic d_ir, input logic d_ov, input logic d_st,
                           input logic [7:0] d_res, input logic d_z, input logic d_n,
                           input logic d_c, input logic d_o, input logic d_sz,
                           input logic [7:0] d_cnt);
      int w, cmod, qs;
      logic exp_ir;
      logic [7:0] rv, front;
      w    = (d == 0) ? 4 : 8;
      cmod = (d == 0) ? 4 : 256;
      qs   = (d == 0) ? exp_q0.size() : exp_q1.size();
      exp_ir = !r && (qs == 0 || ordy);

      check($sformatf("dut%0d in_ready", d), 32'(d_ir), 32'(exp_ir));
      check($sformatf("dut%0d out_valid", d), 32'(d_ov), 32'(qs != 0));
      check($sformatf("dut%0d state", d), 32'(d_st), 32'(qs != 0));
      check($sformatf("dut%0d result", d), 32'(d_res), 32'(m_res[d]));
      check($sformatf("dut%0d zero", d), 32'(d_z), 32'(m_zero[d]));
      check($sformatf("dut%0d negative", d), 32'(d_n), 32'(m_neg[d]));
      check($sformatf("dut%0d carry", d), 32'(d_c), 32'd0);
      check($sformatf("dut%0d overflow", d), 32'(d_o), 32'd0);
      check($sformatf("dut%0d sticky_zero", d), 32'(d_sz), 32'(m_sz[d]));
      check($sformatf("dut%0d op_count", d), 32'(d_cnt), 32'(m_cnt[d]));

      if (r) begin
         if (d == 0) exp_q0.delete(); else exp_q1.delete();
         m_res[d] = '0; m_zero[d] = 1'b0; m_neg[d] = 1'b0;
         m_sz[d] = 1'b0; m_cnt[d] = 0;
      end else begin
         if (qs != 0 && ordy) begin
            front = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("dut%0d delivered", d), 32'(d_res), 32'(front));
         end
         if (iv && exp_ir) begin
            rv = model_op(iop, ia, ib, w);
            if (d == 0) exp_q0.push_back(rv); else exp_q1.push_back(rv);
            m_res[d]  = rv;
            m_zero[d] = (rv == 0);
            m_neg[d]  = rv[w-1];
            m_cnt[d]  = (m_cnt[d] + 1) % cmod;
            if (rv == 0) m_sz[d] = 1'b1;
            else if (sclr) m_sz[d] = 1'b0;
         end else if (sclr) begin
            m_sz[d] = 1'b0;
         end
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (mon_on) begin
         mon_step(0, rst0, if0.in_valid, {4'b0, if0.a}, {4'b0, if0.b}, if0.op,
                  if0.out_ready, sclr0, if0.in_ready, if0.out_valid, st0,
                  {4'b0, if0.result}, if0.zero, if0.negative, if0.carry,
                  if0.overflow, sz0, {6'b0, cnt0});
         mon_step(1, rst1, if1.in_valid, if1.a, if1.b, if1.op,
                  if1.out_ready, sclr1, if1.in_ready, if1.out_valid, st1,
                  if1.result, if1.zero, if1.negative, if1.carry,
                  if1.overflow, sz1, cnt1);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drv(input int d, input logic v, input logic [7:0] aa, input logic [7:0] bb,
                      input logic [1:0] o, input logic ordy, input logic sclr, input logic r);
      @(posedge clk);
      #1;
      if (d == 0) begin
         if0.in_valid = v; if0.a = aa[3:0]; if0.b = bb[3:0]; if0.op = o;
         if0.out_ready = ordy; sclr0 = sclr; rst0 = r;
      end else begin
         if1.in_valid = v; if1.a = aa; if1.b = bb; if1.op = o;
         if1.out_ready = ordy; sclr1 = sclr; rst1 = r;
      end
   endtask

   // Random producer/consumer that holds an unaccepted bundle stable.
   task automatic rand_run(input int d, input int n);
      logic pending, took, v, ordy, sclr, r;
      logic [7:0] aa, bb;
      logic [1:0] o;
      pending = 1'b0;
      v = 1'b0; aa = '0; bb = '0; o = '0;
      for (int i = 0; i < n; i++) begin
         if (!pending) begin
            v  = ($urandom_range(0, 3) != 0);
            aa = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            bb = 8'($urandom);
            o  = 2'($urandom_range(0, 3));
         end
         ordy = ($urandom_range(0, 3) != 0);
         sclr = ($urandom_range(0, 7) == 0);
         r    = ($urandom_range(0, 59) == 0);
         drv(d, v, aa, bb, o, ordy, sclr, r);
         @(negedge clk);
         took = (d == 0) ? (if0.in_valid && if0.in_ready) : (if1.in_valid && if1.in_ready);
         pending = v && !took && !r;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      mon_on = 1'b0;
      rst0 = 1'b1; rst1 = 1'b1; sclr0 = 1'b0; sclr1 = 1'b0;
      if0.in_valid = 1'b0; if0.a = '0; if0.b = '0; if0.op = '0; if0.out_ready = 1'b0;
      if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.op = '0; if1.out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_res[i] = '0; m_zero[i] = 1'b0; m_neg[i] = 1'b0; m_sz[i] = 1'b0; m_cnt[i] = 0;
      end
      repeat (2) @(posedge clk);
      #1 mon_on = 1'b1;

      // dut0: AND 1100 & 1010 -> 1000, negative, count 1
      drv(0, 1, 8'h0C, 8'h0A, 2'b00, 1, 0, 0);
      // AND 0101 & 1010 -> 0000, zero and sticky set
      drv(0, 1, 8'h05, 8'h0A, 2'b00, 1, 0, 0);
      // sticky_clr alone clears
      drv(0, 0, 8'h00, 8'h00, 2'b00, 1, 1, 0);
      // sticky_clr together with a zero-result accept: set wins
      drv(0, 1, 8'h00, 8'h07, 2'b00, 1, 1, 0);
      // XOR 1111 ^ 0011 -> 1100 (count wraps to 0)
      drv(0, 1, 8'h0F, 8'h03, 2'b10, 1, 0, 0);
      // backpressure: result held, new bundle waits
      repeat (3) drv(0, 1, 8'h01, 8'h02, 2'b01, 0, 0, 0);
      // release: back-to-back deliver and accept (count 1)
      drv(0, 1, 8'h01, 8'h02, 2'b01, 1, 0, 0);
      drv(0, 0, 8'h00, 8'h00, 2'b00, 1, 0, 0);
      drv(0, 0, 8'h00, 8'h00, 2'b00, 1, 0, 0);
      rand_run(0, 400);
      drv(0, 0, 8'h00, 8'h00, 2'b00, 1, 0, 0);

      // dut1: NOT 0x00 -> 0xFF, held, then reset while full
      drv(1, 0, 8'h00, 8'h00, 2'b00, 0, 0, 0);
      drv(1, 1, 8'h00, 8'h33, 2'b11, 0, 0, 0);
      drv(1, 0, 8'h00, 8'h00, 2'b00, 0, 0, 0);
      drv(1, 1, 8'h5A, 8'hA5, 2'b00, 0, 0, 1);
      drv(1, 1, 8'h5A, 8'hA5, 2'b00, 1, 0, 1);
      drv(1, 0, 8'h00, 8'h00, 2'b00, 1, 0, 0);
      rand_run(1, 400);
      drv(1, 0, 8'h00, 8'h00, 2'b00, 1, 0, 0);
      repeat (3) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
